fpu_normalize_pipe: RTL

//  Two-stage pipelined post-arithmetic normalizer, directly downstream of FPU_LZD_64. Takes an

---
 rtl/fpu_normalize_pipe_pkg.sv | 33 +++
 rtl/fpu_norm_lshift.sv | 21 ++
 rtl/fpu_normalize_pipe.sv | 111 +++++++++++
 3 files changed

// File: rtl/fpu_normalize_pipe_pkg.sv
// Per-format mantissa/exponent/LZD-index constants shared by the normalizer and the
// leading-zero detector instantiations.
package fpu_normalize_pipe_pkg;

  typedef enum logic [1:0] {FMT_BF16, FMT_HP, FMT_SP, FMT_DP} fmt_e;

  function automatic int fmt_man(fmt_e f);
    case (f)
      FMT_BF16: return 6;
      FMT_HP:   return 9;
      FMT_DP:   return 51;
      default:  return 22;
    endcase
  endfunction

  function automatic int fmt_exp(fmt_e f);
    case (f)
      FMT_HP:  return 5;
      FMT_DP:  return 11;
      default: return 8;
    endcase
  endfunction

  function automatic int fmt_lzd(fmt_e f);
    case (f)
      FMT_BF16: return 3;
      FMT_HP:   return 3;
      FMT_DP:   return 5;
      default:  return 4;
    endcase
  endfunction

endpackage

// File: rtl/fpu_norm_lshift.sv
// Log-depth zero-filling left barrel shifter; stage i shifts by 2**i when amount[i] is set.
module fpu_norm_lshift #(
  parameter int W  = 24,
  parameter int SW = 5
) (
  input  logic [W-1:0]  data,
  input  logic [SW-1:0] amount,
  output logic [W-1:0]  result
);

  logic [SW:0][W-1:0] stage;

  assign stage[0] = data;

  for (genvar i = 0; i < SW; i++) begin : g_stage
    assign stage[i+1] = amount[i] ? (stage[i] << (1 << i)) : stage[i];
  end

  assign result = stage[SW];

endmodule

// File: rtl/fpu_normalize_pipe.sv
// Two-stage post-arithmetic normalizer: stage 1 picks the shift (with subnormal clamp),
// stage 2 shifts the mantissa and adjusts the exponent. Valid/ready on both sides.
module fpu_normalize_pipe
  import fpu_normalize_pipe_pkg::*;
#(
  parameter int MAN = fmt_man(FMT_SP),
  parameter int EXP = fmt_exp(FMT_SP),
  parameter int LZD = fmt_lzd(FMT_SP)
) (
  input  logic           clk,
  input  logic           rst_l,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [MAN+1:0] in_mant,
  input  logic [EXP-1:0] in_exp,
  input  logic [LZD:0]   in_lzc,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [MAN+1:0] out_mant,
  output logic [EXP-1:0] out_exp,
  output logic           out_zero,
  output logic           out_denorm
);

  localparam int W  = MAN + 2;
  localparam int LW = LZD + 1;
  localparam int XW = EXP + 1;

  logic          adv1, adv2;
  logic          s1_valid, s2_valid;
  logic [W-1:0]  s1_mant;
  logic [EXP-1:0] s1_exp;
  logic [LW-1:0] s1_shift;
  logic          s1_zero, s1_clamp;

  logic          zero_c, clamp_c;
  logic [XW-1:0] lzc_x, lzc_sat, exp_x, shift_x;
  logic [W-1:0]  shifted;
  logic [EXP-1:0] exp_c;

  assign adv2      = !s2_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;

  // Comparisons run one bit wider than the exponent so in_exp - 1 and the
  // saturated count never wrap.
  always_comb begin
    zero_c  = (in_mant == '0);
    lzc_x   = XW'(in_lzc);
    lzc_sat = (lzc_x > XW'(W)) ? XW'(W) : lzc_x;
    exp_x   = {1'b0, in_exp};
    shift_x = '0;
    clamp_c = 1'b0;
    if (zero_c || in_exp == '0) begin
      shift_x = '0;
    end else if (lzc_sat < exp_x) begin
      shift_x = lzc_sat;
    end else begin
      shift_x = exp_x - XW'(1);
      clamp_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s1_valid <= 1'b0;
      s1_mant  <= '0;
      s1_exp   <= '0;
      s1_shift <= '0;
      s1_zero  <= 1'b0;
      s1_clamp <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mant  <= in_mant;
        s1_exp   <= in_exp;
        s1_shift <= LW'(shift_x);
        s1_zero  <= zero_c;
        s1_clamp <= clamp_c;
      end
    end
  end

  fpu_norm_lshift #(.W(W), .SW(LW)) u_lshift (
    .data   (s1_mant),
    .amount (s1_shift),
    .result (shifted)
  );

  assign exp_c = (s1_zero || s1_clamp || s1_exp == '0) ? '0 : s1_exp - EXP'(s1_shift);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s2_valid   <= 1'b0;
      out_mant   <= '0;
      out_exp    <= '0;
      out_zero   <= 1'b0;
      out_denorm <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_mant   <= s1_zero ? '0 : shifted;
        out_exp    <= exp_c;
        out_zero   <= s1_zero;
        out_denorm <= !s1_zero && (exp_c == '0);
      end
    end
  end

endmodule
